// File: rtl/fifo_pkg.sv
// Shared types, constants and helpers for the FIFO and later stream blocks.
package fifo_pkg;

    // Width needed to hold an occupancy value from 0 to depth inclusive.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

    // One direction of a valid/ready handshake.
    typedef struct packed {
        logic valid;
        logic ready;
    } hs_t;

    // Per-cycle occupancy operation; the bit layout is {pop, push}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// Flop-based storage: one synchronous write port, one asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_ptr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [DATA_W-1:0]        rd_data
);

    // Contents are deliberately not reset; validity is tracked by the owner.
    logic [DATA_W-1:0] mem [DEPTH];

    // Write the accepted word into the slot addressed by the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FWFT FIFO with valid/ready on both sides,
// flush, occupancy count and programmable almost-full/almost-empty flags.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int CNT_W     = clog2_cnt(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              almost_full_o,
    output logic              almost_empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

    if (DEPTH < 2) begin : g_chk_depth
        $error("param_fifo: DEPTH must be at least 2");
    end
    if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_chk_af
        $error("param_fifo: AF_THRESH must lie in 0..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_chk_ae
        $error("param_fifo: AE_THRESH must lie in 0..DEPTH-1");
    end
    if (CNT_W != clog2_cnt(DEPTH)) begin : g_chk_cnt_w
        $error("param_fifo: CNT_W is derived from DEPTH and must not be overridden");
    end

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_inc;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              mem_we;
    hs_t               wr_hs;
    hs_t               rd_hs;
    fifo_op_e          op;

    // Status and handshake depend only on the registered count, so neither
    // ready_o nor valid_o has a combinational path from valid_i/ready_i.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign wr_hs.valid = valid_i;
    assign wr_hs.ready = ~full;
    assign rd_hs.valid = ~empty;
    assign rd_hs.ready = ready_i;

    assign push = wr_hs.valid & wr_hs.ready;
    assign pop  = rd_hs.valid & rd_hs.ready;
    assign op   = fifo_op_e'({pop, push});

    // Explicit wrap so that non-power-of-two depths index correctly.
    assign wr_ptr_inc = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
    assign rd_ptr_inc = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);

    // Next occupancy from this cycle's completed handshakes.
    always_comb begin
        count_next = count;
        case (op)
            OP_PUSH: count_next = count + CNT_W'(1);
            OP_POP:  count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Pointer and count registers; reset outranks flush, both discard traffic.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
        end
    end

    // A push coinciding with reset or flush is dropped, so it must not write.
    assign mem_we = push & ~rst_i & ~flush_i;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk_i),
        .wr_en   (mem_we),
        .wr_ptr  (wr_ptr),
        .wr_data (data_i),
        .rd_ptr  (rd_ptr),
        .rd_data (head)
    );

    assign ready_o        = wr_hs.ready;
    assign valid_o        = rd_hs.valid;
    assign data_o         = empty ? '0 : head;
    assign count_o        = count;
    assign almost_full_o  = (count >= AF_CNT);
    assign almost_empty_o = (count <= AE_CNT);

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: a DEPTH=8 instance with default
// thresholds and a DEPTH=5 instance with overridden thresholds, both checked
// against a queue-based reference model.
module tb_param_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s   [2];
    logic       flush_s [2];
    logic       vin_s   [2];
    logic       rin_s   [2];
    logic [7:0] din_s   [2];
    logic       rdy_s   [2];
    logic       vout_s  [2];
    logic       af_s    [2];
    logic       ae_s    [2];
    logic [7:0] dout_s  [2];
    logic [3:0] cnt_a;
    logic [2:0] cnt_b;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    int passed = 0;
    int total  = 0;
    logic dp, dq;

    param_fifo #(.DATA_W(8), .DEPTH(8)) dut_a (
        .clk_i(clk), .rst_i(rst_s[0]), .flush_i(flush_s[0]),
        .valid_i(vin_s[0]), .ready_o(rdy_s[0]), .data_i(din_s[0]),
        .valid_o(vout_s[0]), .ready_i(rin_s[0]), .data_o(dout_s[0]),
        .count_o(cnt_a), .almost_full_o(af_s[0]), .almost_empty_o(ae_s[0])
    );

    param_fifo #(.DATA_W(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(2)) dut_b (
        .clk_i(clk), .rst_i(rst_s[1]), .flush_i(flush_s[1]),
        .valid_i(vin_s[1]), .ready_o(rdy_s[1]), .data_i(din_s[1]),
        .valid_o(vout_s[1]), .ready_i(rin_s[1]), .data_o(dout_s[1]),
        .count_o(cnt_b), .almost_full_o(af_s[1]), .almost_empty_o(ae_s[1])
    );

    // Reference model queries
    function automatic int depth_of(input int s);
        return (s != 0) ? 5 : 8;
    endfunction
    function automatic int af_of(input int s);
        return (s != 0) ? 3 : 7;
    endfunction
    function automatic int ae_of(input int s);
        return (s != 0) ? 2 : 1;
    endfunction
    function automatic int msize(input int s);
        return (s != 0) ? q1.size() : q0.size();
    endfunction
    function automatic logic [7:0] mfront(input int s);
        if (msize(s) == 0) return 8'h00;
        return (s != 0) ? q1[0] : q0[0];
    endfunction
    function automatic int o_cnt(input int s);
        return (s != 0) ? int'(cnt_b) : int'(cnt_a);
    endfunction

    // Drive one clock cycle on instance s and advance the model by the rules:
    // push when valid and not full, pop when ready and not empty,
    // reset or flush empties everything.
    task automatic cycle(input int s, input logic v, input logic [7:0] d,
                         input logic r, input logic fl, input logic rs,
                         output logic did_push, output logic did_pop);
        int n;
        n = msize(s);
        vin_s[s] = v; din_s[s] = d; rin_s[s] = r;
        flush_s[s] = fl; rst_s[s] = rs;
        did_push = v && (n < depth_of(s));
        did_pop  = r && (n > 0);
        @(posedge clk);
        #1;
        if (rs || fl) begin
            if (s != 0) q1.delete(); else q0.delete();
        end else begin
            if (did_pop) begin
                if (s != 0) void'(q1.pop_front()); else void'(q0.pop_front());
            end
            if (did_push) begin
                if (s != 0) q1.push_back(d); else q0.push_back(d);
            end
        end
        vin_s[s] = 1'b0; rin_s[s] = 1'b0; flush_s[s] = 1'b0; rst_s[s] = 1'b0;
    endtask

    task automatic test_reset();
        cycle(0, 0, 8'h00, 0, 0, 1, dp, dq);
        cycle(1, 0, 8'h00, 0, 0, 1, dp, dq);
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'($urandom), 0, 0, 0, dp, dq);
        cycle(0, 1, 8'h77, 1, 0, 1, dp, dq);
        for (int s = 0; s < 2; s++) begin
            total++;
            if (vout_s[s] !== 1'b0) $display("FAIL reset_valid[%0d] got %b want 0", s, vout_s[s]);
            else passed++;
            total++;
            if (rdy_s[s] !== 1'b1) $display("FAIL reset_ready[%0d] got %b want 1", s, rdy_s[s]);
            else passed++;
            total++;
            if (o_cnt(s) !== 0) $display("FAIL reset_count[%0d] got %0d want 0", s, o_cnt(s));
            else passed++;
            total++;
            if (af_s[s] !== 1'b0) $display("FAIL reset_af[%0d] got %b want 0", s, af_s[s]);
            else passed++;
            total++;
            if (ae_s[s] !== 1'b1) $display("FAIL reset_ae[%0d] got %b want 1", s, ae_s[s]);
            else passed++;
            total++;
            if (dout_s[s] !== 8'h00) $display("FAIL reset_data[%0d] got %h want 00", s, dout_s[s]);
            else passed++;
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 8'(8'h10 + i), 0, 0, 0, dp, dq);
            total++;
            if (o_cnt(0) !== i + 1) $display("FAIL fill_count[%0d] got %0d want %0d", i, o_cnt(0), i + 1);
            else passed++;
            total++;
            if (af_s[0] !== ((i + 1) >= 7)) $display("FAIL fill_af[%0d] got %b want %b", i, af_s[0], (i + 1) >= 7);
            else passed++;
            total++;
            if (rdy_s[0] !== ((i + 1) < 8)) $display("FAIL fill_ready[%0d] got %b want %b", i, rdy_s[0], (i + 1) < 8);
            else passed++;
        end
        cycle(0, 1, 8'h99, 0, 0, 0, dp, dq);
        total++;
        if (o_cnt(0) !== 8) $display("FAIL fill_overflow_count got %0d want 8", o_cnt(0));
        else passed++;
        total++;
        if (rdy_s[0] !== 1'b0) $display("FAIL fill_overflow_ready got %b want 0", rdy_s[0]);
        else passed++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (vout_s[0] !== 1'b1) $display("FAIL drain_valid[%0d] got %b want 1", i, vout_s[0]);
            else passed++;
            total++;
            if (dout_s[0] !== 8'(8'h10 + i)) $display("FAIL drain_data[%0d] got %h want %h", i, dout_s[0], 8'(8'h10 + i));
            else passed++;
            cycle(0, 0, 8'h00, 1, 0, 0, dp, dq);
        end
        total++;
        if (vout_s[0] !== 1'b0) $display("FAIL drain_end_valid got %b want 0", vout_s[0]);
        else passed++;
        total++;
        if (o_cnt(0) !== 0) $display("FAIL drain_end_count got %0d want 0", o_cnt(0));
        else passed++;
    endtask

    task automatic test_stream(input int s);
        for (int i = 0; i < 3; i++) cycle(s, 1, 8'($urandom), 0, 0, 0, dp, dq);
        for (int i = 0; i < 20; i++) begin
            total++;
            if (dout_s[s] !== mfront(s)) $display("FAIL stream_data[%0d][%0d] got %h want %h", s, i, dout_s[s], mfront(s));
            else passed++;
            cycle(s, 1, 8'($urandom), 1, 0, 0, dp, dq);
            total++;
            if (o_cnt(s) !== 3) $display("FAIL stream_count[%0d][%0d] got %0d want 3", s, i, o_cnt(s));
            else passed++;
        end
        cycle(s, 0, 8'h00, 0, 1, 0, dp, dq);
    endtask

    task automatic test_empty_fwft();
        cycle(0, 1, 8'hA5, 1, 0, 0, dp, dq);
        total++;
        if (vout_s[0] !== 1'b1) $display("FAIL fwft_valid got %b want 1", vout_s[0]);
        else passed++;
        total++;
        if (dout_s[0] !== 8'hA5) $display("FAIL fwft_data got %h want a5", dout_s[0]);
        else passed++;
        total++;
        if (o_cnt(0) !== 1) $display("FAIL fwft_count got %0d want 1", o_cnt(0));
        else passed++;
        cycle(0, 0, 8'h00, 1, 0, 0, dp, dq);
    endtask

    task automatic test_full_both();
        for (int i = 0; i < 8; i++) cycle(0, 1, 8'($urandom_range(0, 200)), 0, 0, 0, dp, dq);
        cycle(0, 1, 8'hEE, 1, 0, 0, dp, dq);
        total++;
        if (o_cnt(0) !== 7) $display("FAIL fullboth_count got %0d want 7", o_cnt(0));
        else passed++;
        total++;
        if (rdy_s[0] !== 1'b1) $display("FAIL fullboth_ready got %b want 1", rdy_s[0]);
        else passed++;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (dout_s[0] !== mfront(0)) $display("FAIL fullboth_data[%0d] got %h want %h", i, dout_s[0], mfront(0));
            else passed++;
            cycle(0, 0, 8'h00, 1, 0, 0, dp, dq);
        end
        total++;
        if (vout_s[0] !== 1'b0) $display("FAIL fullboth_end_valid got %b want 0", vout_s[0]);
        else passed++;
    endtask

    task automatic test_flush(input logic use_rst);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'($urandom), 0, 0, 0, dp, dq);
        cycle(0, 1, 8'h5A, 1, !use_rst, use_rst, dp, dq);
        total++;
        if (o_cnt(0) !== 0) $display("FAIL flush_count[rst=%b] got %0d want 0", use_rst, o_cnt(0));
        else passed++;
        total++;
        if (vout_s[0] !== 1'b0) $display("FAIL flush_valid[rst=%b] got %b want 0", use_rst, vout_s[0]);
        else passed++;
        total++;
        if (ae_s[0] !== 1'b1) $display("FAIL flush_ae[rst=%b] got %b want 1", use_rst, ae_s[0]);
        else passed++;
        total++;
        if (dout_s[0] !== 8'h00) $display("FAIL flush_data[rst=%b] got %h want 00", use_rst, dout_s[0]);
        else passed++;
        cycle(0, 1, 8'h3C, 0, 0, 0, dp, dq);
        total++;
        if (dout_s[0] !== 8'h3C) $display("FAIL flush_refill[rst=%b] got %h want 3c", use_rst, dout_s[0]);
        else passed++;
        cycle(0, 0, 8'h00, 1, 0, 0, dp, dq);
    endtask

    task automatic test_random(input int s);
        logic v, r, fl, rs;
        for (int i = 0; i < 250; i++) begin
            v  = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r  = ((i / 50) % 2 == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 60) == 0);
            rs = ($urandom_range(0, 150) == 0);
            cycle(s, v, 8'($urandom), r, fl, rs, dp, dq);
            total++;
            if (o_cnt(s) !== msize(s)) $display("FAIL rand_count[%0d][%0d] got %0d want %0d", s, i, o_cnt(s), msize(s));
            else passed++;
            total++;
            if (vout_s[s] !== (msize(s) > 0)) $display("FAIL rand_valid[%0d][%0d] got %b want %b", s, i, vout_s[s], msize(s) > 0);
            else passed++;
            total++;
            if (rdy_s[s] !== (msize(s) < depth_of(s))) $display("FAIL rand_ready[%0d][%0d] got %b want %b", s, i, rdy_s[s], msize(s) < depth_of(s));
            else passed++;
            total++;
            if (dout_s[s] !== mfront(s)) $display("FAIL rand_data[%0d][%0d] got %h want %h", s, i, dout_s[s], mfront(s));
            else passed++;
            total++;
            if (af_s[s] !== (msize(s) >= af_of(s))) $display("FAIL rand_af[%0d][%0d] got %b want %b", s, i, af_s[s], msize(s) >= af_of(s));
            else passed++;
            total++;
            if (ae_s[s] !== (msize(s) <= ae_of(s))) $display("FAIL rand_ae[%0d][%0d] got %b want %b", s, i, ae_s[s], msize(s) <= ae_of(s));
            else passed++;
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_s[s] = 1'b1; flush_s[s] = 1'b0; vin_s[s] = 1'b0;
            rin_s[s] = 1'b0; din_s[s] = 8'h00;
        end
        test_reset();
        test_fill();
        test_drain();
        test_stream(0);
        test_stream(1);
        test_empty_fwft();
        test_full_both();
        test_flush(1'b0);
        test_flush(1'b1);
        test_random(0);
        test_random(1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
